// File: rtl/serial_sub.sv
// serial_sub: bit-serial LSB-first subtractor, d = a - b - b_in over WIDTH cycles.
// One full-subtractor cell plus a borrow flip-flop; start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] d,
   output logic             b_out
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, a_sr_nxt;
   logic [WIDTH-1:0] b_sr, b_sr_nxt;
   logic [WIDTH-1:0] r_sr, r_sr_nxt;
   logic             br, br_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             busy_nxt, done_nxt, b_out_nxt;
   logic [WIDTH-1:0] d_nxt;
   logic             x, y, diff_bit, borrow_bit, last_bit;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_nxt;
`endif

   // Full-subtractor cell on the current LSBs and the stored borrow
   assign x          = a_sr[0];
   assign y          = b_sr[0];
   assign diff_bit   = x ^ y ^ br;
   assign borrow_bit = (~x & y) | (~(x ^ y) & br);
   assign last_bit   = (cnt == CW'(WIDTH - 1));

   // Next-state and next-value logic
   always_comb begin
      state_nxt = state;
      a_sr_nxt  = a_sr;
      b_sr_nxt  = b_sr;
      r_sr_nxt  = r_sr;
      br_nxt    = br;
      cnt_nxt   = cnt;
      d_nxt     = d;
      b_out_nxt = b_out;
      done_nxt  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_nxt   = ovf;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               a_sr_nxt  = a;
               b_sr_nxt  = b;
               br_nxt    = b_in;
               cnt_nxt   = '0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            r_sr_nxt = {diff_bit, r_sr[WIDTH-1:1]};
            a_sr_nxt = {1'b0, a_sr[WIDTH-1:1]};
            b_sr_nxt = {1'b0, b_sr[WIDTH-1:1]};
            br_nxt   = borrow_bit;
            cnt_nxt  = cnt + CW'(1);
            if (last_bit) begin
               d_nxt     = {diff_bit, r_sr[WIDTH-1:1]};
               b_out_nxt = borrow_bit;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
`ifdef SERIAL_SUB_OVF_EN
               // br here is the borrow into the MSB
               ovf_nxt   = br ^ borrow_bit;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt == RUN);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         r_sr  <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         d     <= '0;
         b_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         a_sr  <= a_sr_nxt;
         b_sr  <= b_sr_nxt;
         r_sr  <= r_sr_nxt;
         br    <= br_nxt;
         cnt   <= cnt_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         d     <= d_nxt;
         b_out <= b_out_nxt;
`ifdef SERIAL_SUB_OVF_EN
         ovf   <= ovf_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed self-checking bench for serial_sub (WIDTH=4).
// Define SERIAL_SUB_OVF_EN for both files to exercise the ovf output.
module tb_serial_sub;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         b_in;
   logic         busy, done, b_out;
   logic [W-1:0] d;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_sub #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .b_in    (b_in),
      .busy    (busy),
      .done    (done),
`ifdef SERIAL_SUB_OVF_EN
      .ovf     (ovf),
`endif
      .d       (d),
      .b_out   (b_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic e_busy, input logic e_done,
                           input logic [W-1:0] e_d, input logic e_bo, input logic e_ovf);
      chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
      chk({tag, ".done"}, 32'(done), 32'(e_done));
      chk({tag, ".d"}, 32'(d), 32'(e_d));
      chk({tag, ".b_out"}, 32'(b_out), 32'(e_bo));
`ifdef SERIAL_SUB_OVF_EN
      chk({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
`else
      if (e_ovf === 1'bx) $display("unreachable");
`endif
   endtask

   // mode 0: plain, 1: ignored start pulse during RUN, 2: reset during RUN.
   // Returns at the negedge where done is expected (modes 0/1) or after reset release (mode 2).
   task automatic op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic ibin, input logic [W-1:0] e_d, input logic e_bo,
                     input logic e_ovf, input int mode);
      @(negedge clk);
      a = ia; b = ib; b_in = ibin; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < int'(W); i++) begin
         @(negedge clk);
         chk($sformatf("%s.run%0d.busy", tag, i), 32'(busy), 32'd1);
         chk($sformatf("%s.run%0d.done", tag, i), 32'(done), 32'd0);
         if (mode == 1 && i == 1) begin
            a = 4'd5; b = 4'd2; b_in = 1'b0; start = 1'b1;
         end
         if (mode == 1 && i == 2) start = 1'b0;
         if (mode == 2 && i == 1) begin
            #2 reset_n = 1'b0;
            #1 chk_outs({tag, ".rst_now"}, 1'b0, 1'b0, '0, 1'b0, 1'b0);
            repeat (3) begin
               @(negedge clk);
               chk_outs({tag, ".rst_hold"}, 1'b0, 1'b0, '0, 1'b0, 1'b0);
            end
            reset_n = 1'b1;
            repeat (6) begin
               @(negedge clk);
               chk_outs({tag, ".rst_after"}, 1'b0, 1'b0, '0, 1'b0, 1'b0);
            end
            return;
         end
      end
      @(negedge clk);
      chk_outs({tag, ".done"}, 1'b0, 1'b1, e_d, e_bo, e_ovf);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
      repeat (2) @(negedge clk);
      chk_outs("por", 1'b0, 1'b0, '0, 1'b0, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      chk_outs("por_rel", 1'b0, 1'b0, '0, 1'b0, 1'b0);

      // Basic cases; 9-3 and 3-9 overflow as signed 4-bit values
      op("sub9_3", 4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b1, 0);
      @(negedge clk);
      chk_outs("sub9_3.hold", 1'b0, 1'b0, 4'h6, 1'b0, 1'b1);
      op("sub3_9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1, 0);
      op("sub0_0_bin", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, 0);
      op("subF_0_bin", 4'hF, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0, 0);
      op("subF_F_bin", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 0);

      // Overflow cases
      op("ovf7_F", 4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1, 0);
      op("ovf8_1", 4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1, 0);
      op("ovf6_2", 4'h6, 4'h2, 1'b0, 4'h4, 1'b0, 1'b0, 0);

      // Ignored start during RUN, then start held through the done cycle
      op("ign", 4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b1, 1);
      a = 4'd5; b = 4'd2; b_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < int'(W); i++) begin
         @(negedge clk);
         chk($sformatf("b2b.run%0d.busy", i), 32'(busy), 32'd1);
         chk($sformatf("b2b.run%0d.done", i), 32'(done), 32'd0);
         chk($sformatf("b2b.run%0d.d", i), 32'(d), 32'h6);
      end
      @(negedge clk);
      chk_outs("b2b.done", 1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
      @(negedge clk);
      chk_outs("b2b.idle", 1'b0, 1'b0, 4'h3, 1'b0, 1'b0);

      // Asynchronous reset while idle with non-zero result registered
      #2 reset_n = 1'b0;
      #1 chk_outs("rst_idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      // Reset mid-operation, then a fresh operation completes
      op("rst_mid", 4'd3, 4'd9, 1'b0, '0, 1'b0, 1'b0, 2);
      op("post_rst", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1, 0);
      @(negedge clk);
      chk_outs("post_rst.idle", 1'b0, 1'b0, 4'hA, 1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
